// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB pipeline register. It issues loads and stores on a req/ack
// data port, stalls upstream while an access is outstanding and drives the writeback triple.
module mem_wb_stage #(
  parameter int unsigned REG_SIZE     = 32,
  parameter int unsigned REG_NUM_SIZE = 5,
  parameter int unsigned TIMEOUT      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    IN_VALID,
  input  logic [REG_SIZE-1:0]     ALU_RES,
  input  logic [REG_SIZE-1:0]     D2,
  input  logic                    MEM_WE,
  input  logic                    MEM_TO_REG,
  input  logic                    DE_WE,
  input  logic [REG_NUM_SIZE-1:0] RD,
  input  logic [2:0]              FUNCT3,
  output logic                    STALL,
  output logic                    DMEM_REQ,
  output logic                    DMEM_WE,
  output logic [REG_SIZE-1:0]     DMEM_ADDR,
  output logic [REG_SIZE-1:0]     DMEM_WDATA,
  output logic [3:0]              DMEM_BE,
  input  logic [REG_SIZE-1:0]     DMEM_RDATA,
  input  logic                    DMEM_ACK,
  output logic [REG_NUM_SIZE-1:0] WB_A,
  output logic [REG_SIZE-1:0]     WB_D,
  output logic                    WB_WE,
  output logic                    ERR
);

  localparam int unsigned TmoW = $clog2(TIMEOUT);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e                  state_q;
  logic                    dmem_req_q, dmem_we_q, wb_we_q, err_q, de_we_q;
  logic [REG_SIZE-1:0]     dmem_addr_q, dmem_wdata_q, wb_d_q;
  logic [3:0]              dmem_be_q;
  logic [REG_NUM_SIZE-1:0] wb_a_q, rd_q;
  logic [2:0]              funct3_q;
  logic [1:0]              off_q;
  logic [TmoW-1:0]         tmo_q;

  logic                is_mem, legal, aligned, issue, err_set;
  logic [REG_SIZE-1:0] wdata_v, load_v, rsh;
  logic [3:0]          be_v;
  logic [7:0]          byte_v;
  logic [15:0]         half_v;

  // Access decode for the incoming bundle; a store flag takes priority over a load flag.
  always_comb begin
    is_mem = MEM_WE | MEM_TO_REG;
    if (MEM_WE) legal = FUNCT3 inside {3'b000, 3'b001, 3'b010};
    else        legal = FUNCT3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    case (FUNCT3[1:0])
      2'b10:   aligned = (ALU_RES[1:0] == 2'b00);
      2'b01:   aligned = !ALU_RES[0];
      default: aligned = 1'b1;
    endcase
    issue   = legal && aligned;
    err_set = !issue || (MEM_WE && MEM_TO_REG);
    be_v    = 4'b1111;
    wdata_v = D2;
    if (MEM_WE) begin
      case (FUNCT3[1:0])
        2'b00: begin
          wdata_v = {(REG_SIZE/8){D2[7:0]}};
          be_v    = 4'b0001 << ALU_RES[1:0];
        end
        2'b01: begin
          wdata_v = {(REG_SIZE/16){D2[15:0]}};
          be_v    = ALU_RES[1] ? 4'b1100 : 4'b0011;
        end
        default: ;
      endcase
    end
  end

  // Lane extraction for the returning load word.
  always_comb begin
    rsh    = DMEM_RDATA >> {off_q, 3'b000};
    byte_v = rsh[7:0];
    half_v = off_q[1] ? DMEM_RDATA[31:16] : DMEM_RDATA[15:0];
    case (funct3_q)
      3'b000:  load_v = {{(REG_SIZE-8){byte_v[7]}}, byte_v};
      3'b100:  load_v = {{(REG_SIZE-8){1'b0}}, byte_v};
      3'b001:  load_v = {{(REG_SIZE-16){half_v[15]}}, half_v};
      3'b101:  load_v = {{(REG_SIZE-16){1'b0}}, half_v};
      default: load_v = DMEM_RDATA;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      dmem_be_q    <= '0;
      wb_a_q       <= '0;
      wb_d_q       <= '0;
      wb_we_q      <= 1'b0;
      err_q        <= 1'b0;
      rd_q         <= '0;
      de_we_q      <= 1'b0;
      funct3_q     <= '0;
      off_q        <= '0;
      tmo_q        <= '0;
    end else begin
      wb_we_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (IN_VALID && !is_mem) begin
            wb_a_q  <= RD;
            wb_d_q  <= ALU_RES;
            wb_we_q <= DE_WE && (RD != '0);
          end else if (IN_VALID) begin
            if (err_set) err_q <= 1'b1;
            if (issue) begin
              state_q      <= StBusy;
              dmem_req_q   <= 1'b1;
              dmem_we_q    <= MEM_WE;
              dmem_addr_q  <= {ALU_RES[REG_SIZE-1:2], 2'b00};
              dmem_wdata_q <= wdata_v;
              dmem_be_q    <= be_v;
              rd_q         <= RD;
              de_we_q      <= DE_WE;
              funct3_q     <= FUNCT3;
              off_q        <= ALU_RES[1:0];
              tmo_q        <= '0;
            end
          end
        end
        StBusy: begin
          // An ACK arriving in the expiry cycle still completes the access.
          if (DMEM_ACK) begin
            state_q    <= StIdle;
            dmem_req_q <= 1'b0;
            if (!dmem_we_q) begin
              wb_a_q  <= rd_q;
              wb_d_q  <= load_v;
              wb_we_q <= de_we_q && (rd_q != '0);
            end
          end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
            state_q    <= StIdle;
            dmem_req_q <= 1'b0;
            err_q      <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign STALL      = (state_q == StBusy);
  assign DMEM_REQ   = dmem_req_q;
  assign DMEM_WE    = dmem_we_q;
  assign DMEM_ADDR  = dmem_addr_q;
  assign DMEM_WDATA = dmem_wdata_q;
  assign DMEM_BE    = dmem_be_q;
  assign WB_A       = wb_a_q;
  assign WB_D       = wb_d_q;
  assign WB_WE      = wb_we_q;
  assign ERR        = err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: ALU writeback, loads, stores, misalignment, timeout, reset.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        IN_VALID = 1'b0;
  logic [31:0] ALU_RES = '0;
  logic [31:0] D2 = '0;
  logic        MEM_WE = 1'b0;
  logic        MEM_TO_REG = 1'b0;
  logic        DE_WE = 1'b0;
  logic [4:0]  RD = '0;
  logic [2:0]  FUNCT3 = '0;
  logic        STALL, DMEM_REQ, DMEM_WE, WB_WE, ERR;
  logic [31:0] DMEM_ADDR, DMEM_WDATA, WB_D;
  logic [3:0]  DMEM_BE;
  logic [31:0] DMEM_RDATA = '0;
  logic        DMEM_ACK = 1'b0;
  logic [4:0]  WB_A;

  int n_total = 0;
  int n_pass  = 0;
  int stalls;

  mem_wb_stage #(.REG_SIZE(32), .REG_NUM_SIZE(5), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .IN_VALID(IN_VALID), .ALU_RES(ALU_RES), .D2(D2), .MEM_WE(MEM_WE),
    .MEM_TO_REG(MEM_TO_REG), .DE_WE(DE_WE), .RD(RD), .FUNCT3(FUNCT3), .STALL(STALL),
    .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR), .DMEM_WDATA(DMEM_WDATA),
    .DMEM_BE(DMEM_BE), .DMEM_RDATA(DMEM_RDATA), .DMEM_ACK(DMEM_ACK), .WB_A(WB_A), .WB_D(WB_D),
    .WB_WE(WB_WE), .ERR(ERR)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic st, input logic ld, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rd);
    IN_VALID = 1'b1; MEM_WE = st; MEM_TO_REG = ld; FUNCT3 = f3;
    ALU_RES = addr; D2 = data; RD = rd; DE_WE = 1'b1;
    tick();
    IN_VALID = 1'b0; MEM_WE = 1'b0; MEM_TO_REG = 1'b0;
  endtask

  // Counts BUSY cycles; ACK is raised in BUSY cycle ack_cycle (0 = never).
  task automatic run_busy(input int ack_cycle, input logic [31:0] rdata, output int n);
    n = 0;
    for (int i = 1; i <= 40 && STALL; i++) begin
      n++;
      if (i == ack_cycle) begin
        DMEM_ACK = 1'b1;
        DMEM_RDATA = rdata;
      end
      tick();
      DMEM_ACK = 1'b0;
    end
  endtask

  initial begin
    #2;
    check("rst_stall", STALL, 0);
    check("rst_req", DMEM_REQ, 0);
    check("rst_wbwe", WB_WE, 0);
    check("rst_err", ERR, 0);
    check("rst_addr", DMEM_ADDR, 0);
    check("rst_wbd", WB_D, 0);
    tick();
    rst = 1'b0;
    tick();

    // ALU result writeback
    IN_VALID = 1'b1; RD = 5'd5; ALU_RES = 32'h1234; DE_WE = 1'b1;
    tick();
    check("alu_wba", WB_A, 5);
    check("alu_wbd", WB_D, 32'h1234);
    check("alu_wbwe", WB_WE, 1);
    check("alu_stall", STALL, 0);
    RD = 5'd0; ALU_RES = 32'h55;
    tick();
    check("alu_x0_wbwe", WB_WE, 0);
    check("alu_x0_wbd", WB_D, 32'h55);
    IN_VALID = 1'b0;

    // LB from byte 3, ACK in third BUSY cycle
    issue(1'b0, 1'b1, 3'b000, 32'h103, 32'h0, 5'd7);
    check("lb_req", DMEM_REQ, 1);
    check("lb_addr", DMEM_ADDR, 32'h100);
    check("lb_we", DMEM_WE, 0);
    check("lb_be", DMEM_BE, 4'b1111);
    check("lb_bubble", WB_WE, 0);
    run_busy(3, 32'h80FF_FFFF, stalls);
    check("lb_stalls", stalls, 3);
    check("lb_wbd", WB_D, 32'hFFFF_FF80);
    check("lb_wba", WB_A, 7);
    check("lb_wbwe", WB_WE, 1);
    check("lb_req_off", DMEM_REQ, 0);
    tick();
    check("lb_pulse", WB_WE, 0);
    check("lb_hold", WB_D, 32'hFFFF_FF80);

    issue(1'b0, 1'b1, 3'b100, 32'h103, 32'h0, 5'd8);
    run_busy(3, 32'h80FF_FFFF, stalls);
    check("lbu_wbd", WB_D, 32'h0000_0080);

    // LH upper half, minimum latency
    issue(1'b0, 1'b1, 3'b001, 32'h402, 32'h0, 5'd9);
    run_busy(1, 32'h8001_7FFF, stalls);
    check("lh_stalls", stalls, 1);
    check("lh_wbd", WB_D, 32'hFFFF_8001);

    // SH upper half
    issue(1'b1, 1'b0, 3'b001, 32'h202, 32'hABCD_1234, 5'd3);
    check("sh_be", DMEM_BE, 4'b1100);
    check("sh_wdata", DMEM_WDATA, 32'h1234_1234);
    check("sh_we", DMEM_WE, 1);
    check("sh_addr", DMEM_ADDR, 32'h200);
    run_busy(2, 32'h0, stalls);
    check("sh_wbwe", WB_WE, 0);

    issue(1'b1, 1'b0, 3'b000, 32'h501, 32'h0000_00C3, 5'd3);
    check("sb_be", DMEM_BE, 4'b0010);
    check("sb_wdata", DMEM_WDATA, 32'hC3C3_C3C3);
    run_busy(1, 32'h0, stalls);

    // LW with ACK exactly on the expiry cycle
    issue(1'b0, 1'b1, 3'b010, 32'h300, 32'h0, 5'd10);
    run_busy(16, 32'hDEAD_BEEF, stalls);
    check("lw16_stalls", stalls, 16);
    check("lw16_wbd", WB_D, 32'hDEAD_BEEF);
    check("lw16_wbwe", WB_WE, 1);
    check("lw16_err", ERR, 0);

    // LW timeout
    issue(1'b0, 1'b1, 3'b010, 32'h300, 32'h0, 5'd11);
    run_busy(0, 32'h0, stalls);
    check("tmo_stalls", stalls, 16);
    check("tmo_req", DMEM_REQ, 0);
    check("tmo_err", ERR, 1);
    check("tmo_wbwe", WB_WE, 0);
    check("tmo_wba", WB_A, 10);

    // Reset mid-access, late ACK ignored
    issue(1'b0, 1'b1, 3'b010, 32'h600, 32'h0, 5'd12);
    check("mid_req", DMEM_REQ, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_req", DMEM_REQ, 0);
    check("arst_stall", STALL, 0);
    check("arst_wbwe", WB_WE, 0);
    check("arst_err", ERR, 0);
    #1 rst = 1'b0;
    DMEM_ACK = 1'b1; DMEM_RDATA = 32'h1111_1111;
    tick();
    DMEM_ACK = 1'b0;
    check("late_ack_wbwe", WB_WE, 0);
    check("late_ack_stall", STALL, 0);
    check("late_ack_wbd", WB_D, 0);

    // Misaligned LW
    issue(1'b0, 1'b1, 3'b010, 32'h101, 32'h0, 5'd4);
    check("mis_req", DMEM_REQ, 0);
    check("mis_err", ERR, 1);
    check("mis_wbwe", WB_WE, 0);
    check("mis_stall", STALL, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access stage plus MEM/WB pipeline register of the 5-stage RISC-V core.
- Consumes the EX/MEM bundle (ALU result, store data, MEM_WE/DE_WE/MEM_TO_REG, rd, funct3) and performs loads/stores over a req/ack data-memory port.
- Drives the register-file writeback triple WB_A/WB_D/WB_WE back into the decode stage, i.e. it is the writer end of the writeback interface that decode reads.
- Stalls upstream while a memory access is outstanding.

Parameters:
REG_SIZE, 32, data/address width
REG_NUM_SIZE, 5, register index width
TIMEOUT, 16, max cycles waiting for DMEM_ACK before abort (>=2)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
IN_VALID  in  1  EX/MEM bundle valid this cycle
ALU_RES  in  REG_SIZE  ALU result / memory address
D2  in  REG_SIZE  store data
MEM_WE  in  1  store
MEM_TO_REG  in  1  load
DE_WE  in  1  register write enable
RD  in  REG_NUM_SIZE  destination register
FUNCT3  in  3  access size/sign
STALL  out  1  upstream must hold bundle
DMEM_REQ  out  1  memory request
DMEM_WE  out  1  request is write
DMEM_ADDR  out  REG_SIZE  word-aligned address (bits[1:0]=0)
DMEM_WDATA  out  REG_SIZE  lane-replicated store data
DMEM_BE  out  4  byte enables
DMEM_RDATA  in  REG_SIZE  read word, valid with DMEM_ACK
DMEM_ACK  in  1  access complete
WB_A  out  REG_NUM_SIZE  writeback register
WB_D  out  REG_SIZE  writeback data
WB_WE  out  1  writeback enable
ERR  out  1  sticky misalign/timeout flag

Behaviour:
- Reset (async, any time incl. mid-access): state IDLE; STALL, DMEM_REQ, DMEM_WE, WB_WE, ERR = 0; DMEM_ADDR, DMEM_WDATA, WB_D = 0; DMEM_BE = 0; WB_A = 0; timeout counter = 0. A late DMEM_ACK after reset is ignored.
- States: IDLE, BUSY.
- STALL = (state==BUSY), registered-state-derived, no combinational path from inputs.
- IDLE, IN_VALID, no mem op: next edge WB_A=RD, WB_D=ALU_RES, WB_WE=DE_WE && RD!=0. Latency 1.
- IDLE, IN_VALID, mem op (MEM_WE or MEM_TO_REG): check alignment: word (FUNCT3[1:0]=10) needs ALU_RES[1:0]=0; half (01) needs ALU_RES[0]=0. Misaligned or illegal FUNCT3 (011,110,111; stores only 000/001/010 legal): set ERR, WB_WE=0 next edge, stay IDLE, no request. Aligned: latch op, RD, DE_WE, FUNCT3, byte offset; next edge DMEM_REQ=1, DMEM_ADDR={ALU_RES[31:2],2'b00}, DMEM_WE=MEM_WE, state BUSY, WB_WE=0 (bubble).
- MEM_WE and MEM_TO_REG both set: treated as store; ERR set.
- Store lanes: SB WDATA={4{D2[7:0]}}, BE=1<<off; SH WDATA={2{D2[15:0]}}, BE=off[1]?1100:0011; SW WDATA=D2, BE=1111. Loads BE=1111.
- BUSY: DMEM_REQ/ADDR/WE/WDATA/BE held stable until DMEM_ACK. On DMEM_ACK: DMEM_REQ=0 next edge, state IDLE. Load writes back next edge: WB_A=latched RD, WB_WE=DE_WE && RD!=0, WB_D=extracted lane: LB/LBU byte at off sign-/zero-extended; LH/LHU half at off[1]; LW whole word. Store: WB_WE=0.
- Min memory-op latency: accept edge -> BUSY; ACK in first BUSY cycle -> writeback on following edge (2 cycles).
- Timeout counter increments each BUSY cycle without ACK; on reaching TIMEOUT: abort, DMEM_REQ=0, ERR=1, WB_WE=0, IDLE. ACK on same cycle as expiry wins (completes normally).
- IN_VALID ignored while BUSY (upstream holds). WB_WE is a one-cycle pulse per retiring instruction; WB_A/WB_D hold last value otherwise.
- ERR sticky until reset.

Test Plan:
- Reset asserted mid-BUSY (DMEM_REQ=1) -> DMEM_REQ, STALL, WB_WE drop to 0 immediately without clock edge; following ACK has no effect.
- ALU op RD=5, ALU_RES=0x1234 -> next edge WB_A=5, WB_D=0x1234, WB_WE=1, STALL never set; RD=0 -> WB_WE=0.
- LB addr 0x103, ACK after 3 cycles with RDATA=0x80FF_FFFF -> DMEM_ADDR=0x100, STALL high 3 cycles, WB_D=0xFFFF_FF80; repeat LBU -> 0x0000_0080.
- SH addr 0x202, D2=0xABCD_1234 -> DMEM_BE=1100, DMEM_WDATA=0x1234_1234, DMEM_WE=1, WB_WE=0.
- LW addr 0x101 -> no DMEM_REQ, ERR=1, WB_WE=0, state stays IDLE.
- LW with no ACK, TIMEOUT=16 -> STALL high 16 cycles, then DMEM_REQ=0, ERR=1, IDLE; ACK exactly on cycle 16 -> normal writeback, ERR unchanged.
